id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Ports SHALL be, clock and reset first:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- if_id_nextpc  in  32  PC+4 of instruction in ID
- if_id_instruc  in  32  instruction in ID
- id_stall  out  1  combinational; holds Fetch
- id_if_selpcsource  out  1  combinational; redirect Fetch
- id_if_selpctype  out  2  00 branch, 01 register, 10 jump index, 11 exception
- id_if_rega  out  32  rs value (JR target)
- id_if_pcimd2ext  out  32  branch target
- id_if_pcindex  out  32  jump target
- mem_wb_writereg  in  1  writeback enable
- mem_wb_regdest  in  5  writeback register
- mem_wb_writedata  in  32  writeback data
- id_ex_rega, id_ex_regb, id_ex_imedext  out  32 each  registered operands, sign-extended immediate
- id_ex_aluop  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- id_ex_alusrc  out  1  1 = use immediate
- id_ex_memread, id_ex_memwrite, id_ex_writereg  out  1 each
- id_ex_regdest  out  5  destination register

Function
REQ-002 Register file SHALL hold 32x32 bits; r0 reads 0 and ignores writes.
REQ-003 Write SHALL occur on rising clock when mem_wb_writereg=1 and mem_wb_regdest!=0.
REQ-004 Reads of a register written in same cycle SHALL return mem_wb_writedata (bypass).
REQ-005 Decode: R-type op 000000 funct 100000/100010/100100/100101/101010 -> add/sub/and/or/slt, regdest=rd, writereg=1; funct 001000 JR; funct 000000 NOP (no write).
REQ-006 addi 001000 -> add, alusrc=1, regdest=rt; lw 100011 -> memread, writereg, regdest=rt, alusrc; sw 101011 -> memwrite, alusrc, writereg=0.
REQ-007 beq 000100 / bne 000101 SHALL compare rs,rt in ID; j 000010 jumps unconditionally.
REQ-008 id_if_pcimd2ext SHALL be if_id_nextpc + (sign-extended imm16 << 2), modulo 2^32.
REQ-009 id_if_pcindex SHALL be {if_id_nextpc[31:28], instr[25:0], 2'b00}; id_if_rega = bypassed rs value.
REQ-010 id_if_selpcsource=1 SHALL assert, same cycle, for taken beq/bne (type 00), JR (01), j (10), undefined opcode/funct (11, target 0x40), only when id_stall=0 and squash=0.
REQ-011 Instruction fetched alongside a taken branch/jump (delay slot) SHALL execute normally.
REQ-012 Undefined instruction SHALL set a squash flag; next accepted instruction SHALL be replaced by a bubble, flag then cleared.
REQ-013 Hazard: id_stall=1 when id_ex_memread=1, id_ex_regdest!=0, and regdest equals a source register the instruction reads (rs; rt for R-type, beq, bne, sw).
REQ-014 Hazard: id_stall=1 when instruction is beq/bne/JR, id_ex_writereg=1, id_ex_regdest!=0, and regdest matches rs or rt used.
REQ-015 While id_stall=1, ID/EX SHALL load a bubble (memread, memwrite, writereg=0, regdest=0, aluop=000); no redirect.
REQ-016 Otherwise ID/EX SHALL register the decoded instruction on every rising edge (1-cycle latency).
REQ-017 Branch, jump, NOP, undefined and squashed instructions SHALL produce writereg=0, memread=0, memwrite=0 in ID/EX.
REQ-018 Stall and squash coinciding SHALL yield bubble with stall deasserted (squashed instruction has no hazards).

Reset
REQ-019 reset=0 SHALL immediately clear all id_ex_* outputs, squash flag, and all 32 registers to 0, regardless of clock.
REQ-020 Reset released mid-stream SHALL resume from bubble state; first instruction decoded on next edge.

Verification
REQ-021 Write r1=5 via writeback, same cycle decode add r3,r1,r1 -> id_ex_rega=5, id_ex_regb=5, aluop=000, regdest=3.
REQ-022 lw r2 in EX, add r4,r2,r1 in ID -> id_stall=1 one cycle, bubble in ID/EX, then add issued.
REQ-023 beq r1,r1,-1 at nextpc 0x0000_0010 -> selpcsource=1, selpctype=00, pcimd2ext=0x0000_000C.
REQ-024 j 0x0000100 at nextpc 0x1000_0004 -> selpctype=10, pcindex=0x1000_0400; delay slot instruction issued.
REQ-025 opcode 111111 -> selpctype=11, next instruction bubbled, following one issued.
REQ-026 Assert reset mid-stream with r7!=0 -> id_ex_* = 0 at once, r7 reads 0 after release.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: register file with write-through bypass,
// instruction decode, branch/jump resolution, hazard detection and the
// ID/EX pipeline register. Fetch is redirected and stalled combinationally.
module id_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_id_nextpc,
  input  logic [31:0] if_id_instruc,
  output logic        id_stall,
  output logic        id_if_selpcsource,
  output logic [1:0]  id_if_selpctype,
  output logic [31:0] id_if_rega,
  output logic [31:0] id_if_pcimd2ext,
  output logic [31:0] id_if_pcindex,
  input  logic        mem_wb_writereg,
  input  logic [4:0]  mem_wb_regdest,
  input  logic [31:0] mem_wb_writedata,
  output logic [31:0] id_ex_rega,
  output logic [31:0] id_ex_regb,
  output logic [31:0] id_ex_imedext,
  output logic [2:0]  id_ex_aluop,
  output logic        id_ex_alusrc,
  output logic        id_ex_memread,
  output logic        id_ex_memwrite,
  output logic        id_ex_writereg,
  output logic [4:0]  id_ex_regdest
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  function automatic logic signed [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [31:0]        regs [32];
  logic               squash;

  logic [5:0]         opcode_p0, funct_p0;
  logic [4:0]         rs_p0, rt_p0, rd_p0;
  logic signed [31:0] imm_sext_p0;
  logic [31:0]        rs_val_p0, rt_val_p0;

  logic               writereg_p0, memread_p0, memwrite_p0, alusrc_p0;
  logic [2:0]         aluop_p0;
  logic [4:0]         regdest_p0;
  logic               use_rs_p0, use_rt_p0;
  logic               is_cmp_p0, is_jr_p0, is_j_p0, is_undef_p0, taken_p0;
  logic               hazard_p0, bubble_p0;

  assign opcode_p0   = if_id_instruc[31:26];
  assign rs_p0       = if_id_instruc[25:21];
  assign rt_p0       = if_id_instruc[20:16];
  assign rd_p0       = if_id_instruc[15:11];
  assign funct_p0    = if_id_instruc[5:0];
  assign imm_sext_p0 = sign_ext16(if_id_instruc[15:0]);

  // Register reads with same-cycle writeback forwarding; r0 is hardwired zero
  always_comb begin
    rs_val_p0 = regs[rs_p0];
    rt_val_p0 = regs[rt_p0];
    if (mem_wb_writereg && (mem_wb_regdest == rs_p0)) rs_val_p0 = mem_wb_writedata;
    if (mem_wb_writereg && (mem_wb_regdest == rt_p0)) rt_val_p0 = mem_wb_writedata;
    if (rs_p0 == 5'd0) rs_val_p0 = '0;
    if (rt_p0 == 5'd0) rt_val_p0 = '0;
  end

  // Decode opcode/funct into EX controls, source usage and control-flow kind
  always_comb begin
    writereg_p0 = 1'b0;
    memread_p0  = 1'b0;
    memwrite_p0 = 1'b0;
    alusrc_p0   = 1'b0;
    aluop_p0    = ALU_ADD;
    regdest_p0  = 5'd0;
    use_rs_p0   = 1'b0;
    use_rt_p0   = 1'b0;
    is_cmp_p0   = 1'b0;
    is_jr_p0    = 1'b0;
    is_j_p0     = 1'b0;
    is_undef_p0 = 1'b0;
    case (opcode_p0)
      OP_RTYPE: begin
        case (funct_p0)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: begin
            writereg_p0 = 1'b1;
            regdest_p0  = rd_p0;
            use_rs_p0   = 1'b1;
            use_rt_p0   = 1'b1;
            case (funct_p0)
              6'b100010: aluop_p0 = ALU_SUB;
              6'b100100: aluop_p0 = ALU_AND;
              6'b100101: aluop_p0 = ALU_OR;
              6'b101010: aluop_p0 = ALU_SLT;
              default:   aluop_p0 = ALU_ADD;
            endcase
          end
          6'b001000: begin
            is_jr_p0  = 1'b1;
            use_rs_p0 = 1'b1;
          end
          6'b000000: ;
          default:   is_undef_p0 = 1'b1;
        endcase
      end
      OP_ADDI: begin
        writereg_p0 = 1'b1;
        alusrc_p0   = 1'b1;
        regdest_p0  = rt_p0;
        use_rs_p0   = 1'b1;
      end
      OP_LW: begin
        writereg_p0 = 1'b1;
        memread_p0  = 1'b1;
        alusrc_p0   = 1'b1;
        regdest_p0  = rt_p0;
        use_rs_p0   = 1'b1;
      end
      OP_SW: begin
        memwrite_p0 = 1'b1;
        alusrc_p0   = 1'b1;
        use_rs_p0   = 1'b1;
        use_rt_p0   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        is_cmp_p0 = 1'b1;
        use_rs_p0 = 1'b1;
        use_rt_p0 = 1'b1;
      end
      OP_J:    is_j_p0 = 1'b1;
      default: is_undef_p0 = 1'b1;
    endcase
  end

  assign taken_p0 = is_cmp_p0 &&
                    ((opcode_p0 == OP_BEQ) ? (rs_val_p0 == rt_val_p0) : (rs_val_p0 != rt_val_p0));

  // Load-use and branch-operand hazards against the instruction now in EX
  always_comb begin
    hazard_p0 = 1'b0;
    if ((id_ex_regdest != 5'd0) &&
        ((use_rs_p0 && (rs_p0 == id_ex_regdest)) || (use_rt_p0 && (rt_p0 == id_ex_regdest)))) begin
      if (id_ex_memread) hazard_p0 = 1'b1;
      if ((is_cmp_p0 || is_jr_p0) && id_ex_writereg) hazard_p0 = 1'b1;
    end
  end

  // A squashed slot carries no hazards, so squash overrides the stall
  assign id_stall  = hazard_p0 && !squash;
  assign bubble_p0 = hazard_p0 || squash;

  assign id_if_selpcsource = !bubble_p0 && (taken_p0 || is_jr_p0 || is_j_p0 || is_undef_p0);
  assign id_if_selpctype   = is_undef_p0 ? 2'b11 :
                             is_j_p0     ? 2'b10 :
                             is_jr_p0    ? 2'b01 : 2'b00;
  assign id_if_rega        = rs_val_p0;
  assign id_if_pcimd2ext   = if_id_nextpc + {imm_sext_p0[29:0], 2'b00};
  assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

  // Register file write port; r0 is never written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (mem_wb_writereg && (mem_wb_regdest != 5'd0)) begin
      regs[mem_wb_regdest] <= mem_wb_writedata;
    end
  end

  // Squash flag: set by an accepted undefined instruction, consumed by the next slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              squash <= 1'b0;
    else if (squash)         squash <= 1'b0;
    else if (!id_stall && is_undef_p0) squash <= 1'b1;
  end

  // ID/EX pipeline register: decoded instruction, or a bubble on stall/squash
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_rega     <= '0;
      id_ex_regb     <= '0;
      id_ex_imedext  <= '0;
      id_ex_aluop    <= ALU_ADD;
      id_ex_alusrc   <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_writereg <= 1'b0;
      id_ex_regdest  <= 5'd0;
    end else begin
      id_ex_rega    <= rs_val_p0;
      id_ex_regb    <= rt_val_p0;
      id_ex_imedext <= imm_sext_p0;
      if (bubble_p0) begin
        id_ex_aluop    <= ALU_ADD;
        id_ex_alusrc   <= 1'b0;
        id_ex_memread  <= 1'b0;
        id_ex_memwrite <= 1'b0;
        id_ex_writereg <= 1'b0;
        id_ex_regdest  <= 5'd0;
      end else begin
        id_ex_aluop    <= aluop_p0;
        id_ex_alusrc   <= alusrc_p0;
        id_ex_memread  <= memread_p0;
        id_ex_memwrite <= memwrite_p0;
        id_ex_writereg <= writereg_p0;
        id_ex_regdest  <= regdest_p0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus randomized instruction
// streams, checked against a behavioural model through a scoreboard queue.
module tb_id_stage;

  logic        clock = 1'b1;
  logic        reset = 1'b0;
  logic [31:0] if_id_nextpc = '0;
  logic [31:0] if_id_instruc = '0;
  logic        id_stall, id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_rega, id_if_pcimd2ext, id_if_pcindex;
  logic        mem_wb_writereg = 1'b0;
  logic [4:0]  mem_wb_regdest = '0;
  logic [31:0] mem_wb_writedata = '0;
  logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext;
  logic [2:0]  id_ex_aluop;
  logic        id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_writereg;
  logic [4:0]  id_ex_regdest;

  always #5 clock = ~clock;

  id_stage dut (
    .clock(clock), .reset(reset),
    .if_id_nextpc(if_id_nextpc), .if_id_instruc(if_id_instruc),
    .id_stall(id_stall), .id_if_selpcsource(id_if_selpcsource),
    .id_if_selpctype(id_if_selpctype), .id_if_rega(id_if_rega),
    .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_pcindex(id_if_pcindex),
    .mem_wb_writereg(mem_wb_writereg), .mem_wb_regdest(mem_wb_regdest),
    .mem_wb_writedata(mem_wb_writedata),
    .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
    .id_ex_aluop(id_ex_aluop), .id_ex_alusrc(id_ex_alusrc),
    .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
    .id_ex_writereg(id_ex_writereg), .id_ex_regdest(id_ex_regdest)
  );

  typedef struct {
    logic [31:0] rega, regb, imm;
    logic [2:0]  aluop;
    logic        alusrc, mr, mw, wr;
    logic [4:0]  dst;
    bit          chk_ops;
  } exp_t;

  typedef struct {
    bit         wr, mr, mw, src, urs, urt, cmp, jr, j, undef;
    logic [2:0] op;
    logic [4:0] dst;
  } dec_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_regs [32];
  bit          m_squash, m_ex_mr, m_ex_wr;
  logic [4:0]  m_ex_dst;
  logic [5:0]  arith_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs, rt,
                                        input logic [15:0] im);
    return {opc, rs, rt, im};
  endfunction

  // Architectural register value as seen by ID, including the writeback in flight
  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (mem_wb_writereg && mem_wb_regdest == r) return mem_wb_writedata;
    return m_regs[r];
  endfunction

  function automatic dec_t m_decode(input logic [31:0] ins);
    dec_t d;
    d = '{default: 0};
    case (ins[31:26])
      6'd0: begin
        if (ins[5:0] == 6'h20 || ins[5:0] == 6'h22 || ins[5:0] == 6'h24 ||
            ins[5:0] == 6'h25 || ins[5:0] == 6'h2a) begin
          d.wr = 1; d.dst = ins[15:11]; d.urs = 1; d.urt = 1;
          d.op = (ins[5:0] == 6'h20) ? 3'd0 : (ins[5:0] == 6'h22) ? 3'd1 :
                 (ins[5:0] == 6'h24) ? 3'd2 : (ins[5:0] == 6'h25) ? 3'd3 : 3'd4;
        end else if (ins[5:0] == 6'h08) begin
          d.jr = 1; d.urs = 1;
        end else if (ins[5:0] != 6'h00) begin
          d.undef = 1;
        end
      end
      6'd8:  begin d.wr = 1; d.src = 1; d.dst = ins[20:16]; d.urs = 1; end
      6'd35: begin d.wr = 1; d.mr = 1; d.src = 1; d.dst = ins[20:16]; d.urs = 1; end
      6'd43: begin d.mw = 1; d.src = 1; d.urs = 1; d.urt = 1; end
      6'd4, 6'd5: begin d.cmp = 1; d.urs = 1; d.urt = 1; end
      6'd2:  d.j = 1;
      default: d.undef = 1;
    endcase
    return d;
  endfunction

  // One ID cycle: drive, check combinational outputs, queue the ID/EX expectation
  task automatic step(input logic [31:0] ins, input logic [31:0] npc, input logic we,
                      input logic [4:0] wd, input logic [31:0] wdat);
    dec_t        d;
    exp_t        e;
    logic [4:0]  rs, rt;
    logic [31:0] va, vb, imx;
    logic [1:0]  ty;
    bit          hz, st, tk, redir, src_match;
    @(negedge clock);
    reset = 1'b1;
    if_id_instruc = ins;
    if_id_nextpc = npc;
    mem_wb_writereg = we;
    mem_wb_regdest = wd;
    mem_wb_writedata = wdat;
    #1;
    d  = m_decode(ins);
    rs = ins[25:21];
    rt = ins[20:16];
    va = m_read(rs);
    vb = m_read(rt);
    imx = {{16{ins[15]}}, ins[15:0]};
    src_match = (d.urs && rs == m_ex_dst) || (d.urt && rt == m_ex_dst);
    hz = m_ex_dst != 0 && src_match && (m_ex_mr || ((d.cmp || d.jr) && m_ex_wr));
    st = hz && !m_squash;
    tk = d.cmp && ((ins[31:26] == 6'd4) ? (va == vb) : (va != vb));
    redir = !st && !m_squash && (tk || d.jr || d.j || d.undef);
    ty = d.undef ? 2'b11 : d.j ? 2'b10 : d.jr ? 2'b01 : 2'b00;
    chk("id_stall", 32'(id_stall), 32'(st));
    chk("selpcsource", 32'(id_if_selpcsource), 32'(redir));
    if (redir) chk("selpctype", 32'(id_if_selpctype), 32'(ty));
    chk("pcimd2ext", id_if_pcimd2ext, npc + (imx << 2));
    chk("pcindex", id_if_pcindex, {npc[31:28], ins[25:0], 2'b00});
    chk("id_if_rega", id_if_rega, va);
    e = '{default: 0};
    if (!(m_squash || st)) begin
      e.rega = va; e.regb = vb; e.imm = imx; e.aluop = d.op; e.alusrc = d.src;
      e.mr = d.mr; e.mw = d.mw; e.wr = d.wr; e.dst = d.wr ? d.dst : 5'd0;
      e.chk_ops = 1;
    end
    sbq.push_back(e);
    m_ex_mr  = e.mr;
    m_ex_wr  = e.wr;
    m_ex_dst = e.dst;
    m_squash = !m_squash && !st && d.undef;
    if (we && wd != 0) m_regs[wd] = wdat;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately
  task automatic do_reset();
    exp_t e;
    @(negedge clock);
    mem_wb_writereg = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_rega", id_ex_rega, 32'd0);
    chk("rst_regb", id_ex_regb, 32'd0);
    chk("rst_imedext", id_ex_imedext, 32'd0);
    chk("rst_ctrl", {21'd0, id_ex_aluop, id_ex_alusrc, id_ex_memread, id_ex_memwrite,
                     id_ex_writereg, id_ex_regdest}, 32'd0);
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_squash = 0; m_ex_mr = 0; m_ex_wr = 0; m_ex_dst = '0;
    e = '{default: 0};
    e.chk_ops = 1;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  a, b, c;
    logic [15:0] im;
    a  = 5'($urandom_range(0, 7));
    b  = 5'($urandom_range(0, 7));
    c  = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 11: return enc_r(c, a, b, arith_fn[$urandom_range(0, 4)]);
      1:  return enc_r(5'd0, a, 5'd0, 6'h08);
      2:  return 32'd0;
      3:  return enc_i(6'd8, a, b, im);
      4:  return enc_i(6'd35, a, b, im);
      5:  return enc_i(6'd43, a, b, im);
      6:  return enc_i(6'd4, a, b, im);
      7:  return enc_i(6'd5, a, b, im);
      8:  return {6'd2, 26'($urandom)};
      9:  return {6'b111111, 26'($urandom)};
      default: return enc_r(c, a, b, 6'h3f);
    endcase
  endfunction

  // Monitor: every edge the DUT presents a new ID/EX word; compare with the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: ID/EX update with no expectation queued (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk("ex_memread", 32'(id_ex_memread), 32'(e.mr));
        chk("ex_memwrite", 32'(id_ex_memwrite), 32'(e.mw));
        chk("ex_writereg", 32'(id_ex_writereg), 32'(e.wr));
        chk("ex_regdest", 32'(id_ex_regdest), 32'(e.dst));
        chk("ex_aluop", 32'(id_ex_aluop), 32'(e.aluop));
        if (e.chk_ops) begin
          chk("ex_alusrc", 32'(id_ex_alusrc), 32'(e.alusrc));
          chk("ex_rega", id_ex_rega, e.rega);
          chk("ex_regb", id_ex_regb, e.regb);
          chk("ex_imedext", id_ex_imedext, e.imm);
        end
      end
    end
  end

  initial begin
    do_reset();
    // write r1=5 while decoding add r3,r1,r1
    step(enc_r(5'd3, 5'd1, 5'd1, 6'h20), 32'h4, 1'b1, 5'd1, 32'd5);
    // lw r2 then dependent add: one stall, then issue
    step(enc_i(6'd35, 5'd0, 5'd2, 16'h0010), 32'h8, 1'b0, 5'd0, 32'd0);
    step(enc_r(5'd4, 5'd2, 5'd1, 6'h20), 32'hC, 1'b0, 5'd0, 32'd0);
    step(enc_r(5'd4, 5'd2, 5'd1, 6'h20), 32'hC, 1'b1, 5'd2, 32'd9);
    // beq r1,r1,-1 at nextpc 0x10, then delay slot
    step(enc_i(6'd4, 5'd1, 5'd1, 16'hFFFF), 32'h10, 1'b0, 5'd0, 32'd0);
    chk("beq_target", id_if_pcimd2ext, 32'h0000_000C);
    step(enc_i(6'd8, 5'd1, 5'd5, 16'h0007), 32'h14, 1'b0, 5'd0, 32'd0);
    // j 0x100 at nextpc 0x1000_0004, then delay slot
    step({6'd2, 26'h000_0100}, 32'h1000_0004, 1'b0, 5'd0, 32'd0);
    chk("j_target", id_if_pcindex, 32'h1000_0400);
    step(enc_r(5'd6, 5'd1, 5'd1, 6'h20), 32'h1000_0008, 1'b0, 5'd0, 32'd0);
    // undefined opcode: next slot bubbled, following one issued
    step(32'hFC00_0000, 32'h20, 1'b0, 5'd0, 32'd0);
    step(enc_r(5'd7, 5'd1, 5'd1, 6'h20), 32'h44, 1'b0, 5'd0, 32'd0);
    step(enc_r(5'd7, 5'd1, 5'd1, 6'h20), 32'h48, 1'b1, 5'd7, 32'd11);
    // r7 nonzero, reset mid-stream, r7 then reads zero
    step(enc_r(5'd8, 5'd7, 5'd0, 6'h20), 32'h4C, 1'b0, 5'd0, 32'd0);
    do_reset();
    step(enc_r(5'd8, 5'd7, 5'd0, 6'h20), 32'h50, 1'b0, 5'd0, 32'd0);
    // randomized stream with occasional reset
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(rand_ins(), {$urandom} & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)));
    end
    @(posedge clock);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
